// File: rtl/axis_i2c_cmd_packer.sv
// Packs an AXI-Stream packet (address beat followed by data beats) into
// {data, addr} writes for the I2C command FIFO, flagging short and overlong packets.
module axis_i2c_cmd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int MAX_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  pkt_done,
  output logic                  err_short,
  output logic                  err_len
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  // ST_ADDR: expect address beat | ST_DATA: forward data beats | ST_DROP: discard until tlast
  typedef enum logic [1:0] {ST_ADDR, ST_DATA, ST_DROP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr_lat;
  logic                  w_ready_st;
  logic                  w_accept;
  logic                  w_at_max;

  // A data beat is only taken once the previous write has cleared, so
  // fifo_full always reflects every write already issued.
  always_comb begin
    w_ready_st = 1'b0;
    unique case (r_state)
      ST_ADDR: w_ready_st = 1'b1;
      ST_DATA: w_ready_st = ~fifo_full & ~fifo_wr_en;
      ST_DROP: w_ready_st = 1'b1;
      default: w_ready_st = 1'b0;
    endcase
  end

  assign s_axis_tready = w_ready_st & ~arst;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_at_max      = (r_cnt == CNT_W'(MAX_LEN - 1));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= ST_ADDR;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_ADDR: if (w_accept && !s_axis_tlast) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_accept) begin
          if (s_axis_tlast)  w_state_nxt = ST_ADDR;
          else if (w_at_max) w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: if (w_accept && s_axis_tlast) w_state_nxt = ST_ADDR;
      default: w_state_nxt = ST_ADDR;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt      <= '0;
      r_addr_lat <= '0;
      addr       <= '0;
      data       <= '0;
      fifo_wr_en <= 1'b0;
      pkt_done   <= 1'b0;
      err_short  <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      pkt_done   <= 1'b0;
      err_short  <= 1'b0;
      err_len    <= 1'b0;
      if (w_accept) begin
        unique case (r_state)
          ST_ADDR: begin
            r_addr_lat <= s_axis_tdata[ADDR_WIDTH-1:0];
            r_cnt      <= '0;
            err_short  <= s_axis_tlast;
          end
          ST_DATA: begin
            fifo_wr_en <= 1'b1;
            data       <= s_axis_tdata;
            addr       <= r_addr_lat;
            r_cnt      <= r_cnt + CNT_W'(1);
            pkt_done   <= s_axis_tlast;
            err_len    <= ~s_axis_tlast & w_at_max;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_i2c_cmd_packer.sv
// Bench for axis_i2c_cmd_packer (MAX_LEN=4): packet-level reference model checked
// every cycle, plus directed packets with literal expected FIFO writes.
module tb_axis_i2c_cmd_packer;

  localparam int DW = 8;
  localparam int AW = 7;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          fifo_wr_en;
  logic          fifo_full = 1'b0;
  logic          pkt_done;
  logic          err_short;
  logic          err_len;

  axis_i2c_cmd_packer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LEN(ML)) dut (
    .clk(clk), .arst(arst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .addr(addr), .data(data), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .pkt_done(pkt_done), .err_short(err_short), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          pd;
    logic          el;
  } rec_t;
  rec_t wr_log[$];
  int   n_short = 0;
  int   n_len   = 0;
  int   n_done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pos = 0 while waiting for the address beat, otherwise the
  // 1-based index of the next data beat; dropping = discarding the overlong tail.
  int            m_pos = 0;
  bit            m_drop = 1'b0;
  logic [AW-1:0] m_paddr = '0;
  logic          m_wr = 1'b0, m_pd = 1'b0, m_es = 1'b0, m_el = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [AW-1:0] m_addr = '0;

  always @(negedge clk) begin
    logic m_rdy;
    logic acc;
    if (arst) begin
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_outs", {22'd0, fifo_wr_en, pkt_done, err_short, err_len, addr[3:0], data[3:0]}, 32'd0);
      chk("rst_bus", {17'd0, addr, data}, 32'd0);
      m_pos = 0; m_drop = 1'b0; m_paddr = '0;
      m_wr = 1'b0; m_pd = 1'b0; m_es = 1'b0; m_el = 1'b0;
      m_data = '0; m_addr = '0;
    end else begin
      chk("wr_en", 32'(fifo_wr_en), 32'(m_wr));
      chk("pkt_done", 32'(pkt_done), 32'(m_pd));
      chk("err_short", 32'(err_short), 32'(m_es));
      chk("err_len", 32'(err_len), 32'(m_el));
      chk("data", 32'(data), 32'(m_data));
      chk("addr", 32'(addr), 32'(m_addr));
      if (fifo_wr_en) wr_log.push_back('{d: data, a: addr, pd: pkt_done, el: err_len});
      if (err_short) n_short++;
      if (err_len)   n_len++;
      if (pkt_done)  n_done++;

      m_rdy = (m_pos == 0) || m_drop || (!fifo_full && !m_wr);
      chk("tready", 32'(s_axis_tready), 32'(m_rdy));
      acc = s_axis_tvalid && m_rdy;

      m_wr = 1'b0; m_pd = 1'b0; m_es = 1'b0; m_el = 1'b0;
      if (acc) begin
        if (m_pos == 0) begin
          m_paddr = s_axis_tdata[AW-1:0];
          if (s_axis_tlast) m_es = 1'b1;
          else              m_pos = 1;
        end else if (m_drop) begin
          if (s_axis_tlast) begin m_pos = 0; m_drop = 1'b0; end
        end else begin
          m_wr = 1'b1; m_data = s_axis_tdata; m_addr = m_paddr;
          if (s_axis_tlast) begin m_pd = 1'b1; m_pos = 0; end
          else if (m_pos == ML) begin m_el = 1'b1; m_drop = 1'b1; end
          else m_pos++;
        end
      end
    end
  end

  // Drive one beat and hold it until the handshake completes; returns at posedge+1.
  task automatic send(input logic [7:0] d, input logic last);
    logic ok;
    s_axis_tdata = d; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); ok = s_axis_tready;
      @(posedge clk); #1;
      if (ok) return;
    end
    checks++; errors++;
    $display("FAIL send_timeout: beat 0x%0h not accepted, expected acceptance within 40 cycles", d);
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_log();
    wr_log.delete(); n_short = 0; n_len = 0; n_done = 0;
  endtask

  task automatic chk_rec(input string name, input int idx, input logic [7:0] d, input logic [6:0] a);
    if (idx < wr_log.size()) begin
      chk({name, "_data"}, 32'(wr_log[idx].d), 32'(d));
      chk({name, "_addr"}, 32'(wr_log[idx].a), 32'(a));
    end else begin
      checks++; errors++;
      $display("FAIL %s: write %0d missing, only %0d writes", name, idx, wr_log.size());
    end
  endtask

  // In ADDR or DROP tready ignores fifo_full; in DATA it would drop.
  task automatic chk_idle_state(input string name);
    fifo_full = 1'b1; #1;
    chk(name, 32'(s_axis_tready), 32'd1);
    fifo_full = 1'b0;
  endtask

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_hold_tready", 32'(s_axis_tready), 32'd0);
    arst = 1'b0; #1;
    chk("post_rst_tready", 32'(s_axis_tready), 32'd1);
    idle(2);

    // Basic packet, tvalid held high across beats
    clear_log();
    send(8'h50, 1'b0); send(8'hA1, 1'b0); send(8'hB2, 1'b1);
    idle(4);
    chk("t1_nwr", 32'(wr_log.size()), 32'd2);
    chk_rec("t1_w0", 0, 8'hA1, 7'h50);
    chk_rec("t1_w1", 1, 8'hB2, 7'h50);
    if (wr_log.size() == 2) begin
      chk("t1_pd0", 32'(wr_log[0].pd), 32'd0);
      chk("t1_pd1", 32'(wr_log[1].pd), 32'd1);
    end
    chk_idle_state("t1_in_addr");

    // Address-only packet, then masked address 0x91 -> 0x11
    clear_log();
    send(8'h3C, 1'b1); idle(3);
    chk("t2_nwr", 32'(wr_log.size()), 32'd0);
    chk("t2_short", 32'(n_short), 32'd1);
    send(8'h91, 1'b0); send(8'h99, 1'b1); idle(3);
    chk("t2_nwr2", 32'(wr_log.size()), 32'd1);
    chk_rec("t2_w0", 0, 8'h99, 7'h11);
    chk("t2_short2", 32'(n_short), 32'd1);

    // FIFO full stall for 5 cycles
    clear_log();
    send(8'h20, 1'b0);
    fifo_full = 1'b1; s_axis_tdata = 8'h77; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t3_stall_tready", 32'(s_axis_tready), 32'd0);
      @(posedge clk); #1;
    end
    chk("t3_nwr_stall", 32'(wr_log.size()), 32'd0);
    fifo_full = 1'b0;
    send(8'h77, 1'b1); idle(4);
    chk("t3_nwr", 32'(wr_log.size()), 32'd1);
    chk_rec("t3_w0", 0, 8'h77, 7'h20);

    // Overlong: 6 data beats with MAX_LEN=4
    clear_log();
    send(8'h01, 1'b0);
    for (int i = 0; i < 6; i++) send(8'(8'h10 + i), i == 5);
    idle(4);
    chk("t4_nwr", 32'(wr_log.size()), 32'd4);
    chk_rec("t4_w3", 3, 8'h13, 7'h01);
    if (wr_log.size() == 4) begin
      chk("t4_el3", 32'(wr_log[3].el), 32'd1);
      chk("t4_el2", 32'(wr_log[2].el), 32'd0);
    end
    chk("t4_nlen", 32'(n_len), 32'd1);
    chk("t4_ndone", 32'(n_done), 32'd0);
    chk_idle_state("t4_in_addr");
    clear_log();
    send(8'h5A, 1'b0); send(8'h6B, 1'b1); idle(3);
    chk_rec("t4_next", 0, 8'h6B, 7'h5A);

    // Exactly MAX_LEN data beats, tlast on the last
    clear_log();
    send(8'h82, 1'b0);
    for (int i = 0; i < 4; i++) send(8'(8'h21 + i), i == 3);
    idle(4);
    chk("t5_nwr", 32'(wr_log.size()), 32'd4);
    chk_rec("t5_w0", 0, 8'h21, 7'h02);
    chk_rec("t5_w3", 3, 8'h24, 7'h02);
    chk("t5_ndone", 32'(n_done), 32'd1);
    chk("t5_nlen", 32'(n_len), 32'd0);

    // Reset mid-packet
    clear_log();
    send(8'h22, 1'b0); send(8'hAB, 1'b0);
    s_axis_tvalid = 1'b0;
    chk("t6_pre_wr", 32'(fifo_wr_en), 32'd1);
    #2 arst = 1'b1; #1;
    chk("t6_async_wr", 32'(fifo_wr_en), 32'd0);
    chk("t6_async_bus", {17'd0, addr, data}, 32'd0);
    chk("t6_async_tready", 32'(s_axis_tready), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    arst = 1'b0;
    clear_log();
    send(8'h33, 1'b0); send(8'h44, 1'b1); idle(4);
    chk("t6_nwr", 32'(wr_log.size()), 32'd1);
    chk_rec("t6_w0", 0, 8'h44, 7'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
